// File: rtl/ppu_mode_sequencer_pkg.sv
// Shared PPU mode encoding and scanline timing constants for the sequencer and fetcher.
// Latency: none. This file holds only types and constants.
// Backpressure: none.
package ppu_pkg;

  typedef enum logic [1:0] {
    HBlank  = 2'd0,
    VBlank  = 2'd1,
    OamScan = 2'd2,
    Drawing = 2'd3
  } PpuMode;

  localparam int DOTS_PER_LINE   = 456;
  localparam int OAM_DOTS        = 80;
  localparam int X_MAX           = 160;
  localparam int VISIBLE_LINES   = 144;
  localparam int TOTAL_SCANLINES = 154;
  localparam int MODE3_MAX_DOTS  = 289;

  localparam int DOT_W = 9;
  localparam int X_W   = $clog2(X_MAX);
  localparam int Y_W   = $clog2(TOTAL_SCANLINES);

  // First dot at which a still-running mode 3 is cut short.
  localparam int WATCHDOG_DOT = OAM_DOTS + MODE3_MAX_DOTS - 1;

  // LY is compared against 8-bit registers (WY, LYC) zero-extended.
  function automatic logic [7:0] y_ext(input logic [Y_W-1:0] y);
    return 8'(y);
  endfunction

endpackage

// File: rtl/ppu_mode_sequencer_if.sv
// Register-file / fetcher side bundle of the PPU mode sequencer; slave = sequencer, master = its environment.
// Latency: none. Wires only.
// Backpressure: none. advance_X_in is a free-running pulse with no handshake.
interface ppu_mode_sequencer_if;
  import ppu_pkg::*;

  logic             lcd_ena_in;
  logic             advance_X_in;
  logic             window_ena_in;
  logic [7:0]       WY_in;
  logic [7:0]       LYC_in;
  logic [3:0]       stat_sel_in;

  PpuMode           mode_out;
  logic [X_W-1:0]   X_out;
  logic [Y_W-1:0]   Y_out;
  logic [DOT_W-1:0] dot_out;
  logic             WY_cond_out;
  logic             fetch_start_out;
  logic             lyc_eq_out;
  logic             vblank_irq_out;
  logic             stat_irq_out;
  logic             mode3_overrun_out;

`ifdef WINDOW_LINE_CTR_EN
  logic             win_drawn_in;
  logic [7:0]       win_line_out;
`endif

  modport slave (
    input  lcd_ena_in, advance_X_in, window_ena_in, WY_in, LYC_in, stat_sel_in,
`ifdef WINDOW_LINE_CTR_EN
    input  win_drawn_in,
    output win_line_out,
`endif
    output mode_out, X_out, Y_out, dot_out, WY_cond_out, fetch_start_out,
    output lyc_eq_out, vblank_irq_out, stat_irq_out, mode3_overrun_out
  );

  modport master (
    output lcd_ena_in, advance_X_in, window_ena_in, WY_in, LYC_in, stat_sel_in,
`ifdef WINDOW_LINE_CTR_EN
    output win_drawn_in,
    input  win_line_out,
`endif
    input  mode_out, X_out, Y_out, dot_out, WY_cond_out, fetch_start_out,
    input  lyc_eq_out, vblank_irq_out, stat_irq_out, mode3_overrun_out
  );

endinterface

// File: rtl/evt_counter.sv
// Generic event counter: counts enabled events 0..MAX then wraps to 0; synchronous clear has priority.
// Latency: count updates on the clock edge that samples inc/clr; at_max is combinational from count.
// Backpressure: none.
module evt_counter #(
  parameter int WIDTH = 9,
  parameter int MAX   = 455
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == WIDTH'(MAX));

  // Clear wins over increment; an increment at MAX rolls over to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ppu_mode_sequencer_stat_irq.sv
// STAT interrupt source: ORs the enabled mode/LYC sources into the STAT line and pulses on its rising edge.
// Latency: irq is registered one T-cycle edge after the line rises.
// Backpressure: none. A line that stays high blocks further pulses until it drops.
module ppu_stat_irq
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] sel,
  input  PpuMode     mode,
  input  logic       lyc_eq,
  output logic       irq
);

  logic stat_line;
  logic line_prev;

  // Combined STAT line from the enabled sources.
  always_comb begin
    stat_line = (sel[0] && (mode == HBlank))  ||
                (sel[1] && (mode == VBlank))  ||
                (sel[2] && (mode == OamScan)) ||
                (sel[3] && lyc_eq);
  end

  // Rising-edge detect on T-cycle edges; clr drops the history so re-enable starts from low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_prev <= 1'b0;
      irq       <= 1'b0;
    end else if (!en) begin
      irq       <= 1'b0;
    end else if (clr) begin
      line_prev <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq       <= stat_line && !line_prev;
      line_prev <= stat_line;
    end
  end

endmodule

// File: rtl/ppu_mode_sequencer.sv
// PPU scanline/frame sequencer: dot/LY/X counters, mode FSM, window-Y latch, VBlank and STAT IRQs. Window line counter under WINDOW_LINE_CTR_EN.
// Latency: all outputs registered; mode/counters move on the T-cycle edge, pixel X on any clk edge.
// Backpressure: none. advance_X_in pulses are consumed only in Drawing and ignored elsewhere.
module ppu_mode_sequencer
  import ppu_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  tclk_in,
  ppu_mode_sequencer_if.slave   bus
);

  localparam logic [DOT_W-1:0] DOT_OAM_LAST = DOT_W'(OAM_DOTS - 1);
  localparam logic [DOT_W-1:0] DOT_WD_LAST  = DOT_W'(WATCHDOG_DOT - 1);
  localparam logic [X_W-1:0]   X_LAST       = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0]   Y_LAST       = Y_W'(TOTAL_SCANLINES - 1);
  localparam logic [7:0]       Y_VIS        = 8'(VISIBLE_LINES);

  PpuMode           mode;
  logic             running;      // LCD was already enabled on the previous T-cycle edge
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [Y_W-1:0]   y_next_line;
  logic [DOT_W-1:0] dot;
  logic             line_end;
  logic             live;
  logic             wy_hit_next;
  logic             wy_hit_zero;
  logic             wy_cond;
  logic             overrun;
  logic             fetch_start;
  logic             vblank_irq;
  logic             lyc_eq;

  // Timing advances only while the LCD is on and has been on for at least one edge.
  assign live = bus.lcd_ena_in && running;

  evt_counter #(
    .WIDTH (DOT_W),
    .MAX   (DOTS_PER_LINE - 1)
  ) u_dot_ctr (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .clr    (tclk_in && !live),
    .inc    (tclk_in && live),
    .count  (dot),
    .at_max (line_end)
  );

  // Next LY and window-Y match for the line that starts at the coming wrap.
  always_comb begin
    y_next_line = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
    wy_hit_next = bus.window_ena_in && (y_ext(y_next_line) < Y_VIS) &&
                  (y_ext(y_next_line) == bus.WY_in);
    wy_hit_zero = bus.window_ena_in && (bus.WY_in == 8'd0);
  end

  // Mode FSM with LY, pixel X, window latch, watchdog and pulse outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      running     <= 1'b1;
      mode        <= OamScan;
      x_q         <= '0;
      y_q         <= '0;
      wy_cond     <= 1'b0;
      overrun     <= 1'b0;
      fetch_start <= 1'b0;
      vblank_irq  <= 1'b0;
      lyc_eq      <= 1'b0;
    end else begin
      fetch_start <= 1'b0;
      vblank_irq  <= 1'b0;

      // Pixel pushes are counted on every clk edge, saturating at the last pixel.
      if (mode == Drawing && bus.advance_X_in && x_q != X_LAST) begin
        x_q <= x_q + X_W'(1);
      end

      if (tclk_in) begin
        lyc_eq <= (y_ext(y_q) == bus.LYC_in);

        if (!bus.lcd_ena_in) begin
          running <= 1'b0;
          mode    <= HBlank;
          x_q     <= '0;
          y_q     <= '0;
          wy_cond <= 1'b0;
        end else if (!running) begin
          // First edge after enable: line 0, dot 0 begins here.
          running <= 1'b1;
          mode    <= OamScan;
          x_q     <= '0;
          y_q     <= '0;
          wy_cond <= wy_hit_zero;
        end else begin
          if (line_end) begin
            y_q <= y_next_line;
            if (y_next_line == '0) begin
              wy_cond <= 1'b0;
            end
            if (wy_hit_next) begin
              wy_cond <= 1'b1;
            end
          end

          case (mode)
            OamScan: begin
              if (dot == DOT_OAM_LAST) begin
                mode        <= Drawing;
                x_q         <= '0;
                fetch_start <= 1'b1;
              end
            end
            Drawing: begin
              if (x_q == X_LAST) begin
                mode <= HBlank;
              end else if (dot == DOT_WD_LAST) begin
                mode    <= HBlank;
                overrun <= 1'b1;
              end
            end
            HBlank: begin
              if (line_end) begin
                if (y_ext(y_next_line) < Y_VIS) begin
                  mode <= OamScan;
                end else begin
                  mode       <= VBlank;
                  vblank_irq <= 1'b1;
                end
              end
            end
            VBlank: begin
              if (line_end && y_next_line == '0) begin
                mode <= OamScan;
              end
            end
            default: mode <= HBlank;
          endcase
        end
      end
    end
  end

  ppu_stat_irq u_stat (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .en     (tclk_in),
    .clr    (!live),
    .sel    (bus.stat_sel_in),
    .mode   (mode),
    .lyc_eq (lyc_eq),
    .irq    (bus.stat_irq_out)
  );

`ifdef WINDOW_LINE_CTR_EN
  logic       win_seen;
  logic [7:0] win_line;

  // Window row counter: advances at the end of any line where the fetcher switched to the window.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      win_seen <= 1'b0;
      win_line <= 8'd0;
    end else begin
      if (bus.win_drawn_in) begin
        win_seen <= 1'b1;
      end
      if (tclk_in) begin
        if (!live) begin
          win_seen <= 1'b0;
          win_line <= 8'd0;
        end else if (line_end) begin
          win_seen <= 1'b0;
          if (y_next_line == '0) begin
            win_line <= 8'd0;
          end else if (win_seen || bus.win_drawn_in) begin
            win_line <= win_line + 8'd1;
          end
        end
      end
    end
  end

  assign bus.win_line_out = win_line;
`endif

  assign bus.mode_out          = mode;
  assign bus.X_out             = x_q;
  assign bus.Y_out             = y_q;
  assign bus.dot_out           = dot;
  assign bus.WY_cond_out       = wy_cond;
  assign bus.fetch_start_out   = fetch_start;
  assign bus.lyc_eq_out        = lyc_eq;
  assign bus.vblank_irq_out    = vblank_irq;
  assign bus.mode3_overrun_out = overrun;

endmodule
